// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: MEM-stage address map, timer control bits and
// control-word bit positions so the ID-stage decoder and the MEM stage agree.
package mips_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH     = PERIPH_BASE + 32'h00;
  localparam logic [31:0] ADDR_TL     = PERIPH_BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON   = PERIPH_BASE + 32'h08;
  localparam logic [31:0] ADDR_LED    = PERIPH_BASE + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH = PERIPH_BASE + 32'h10;
  localparam logic [31:0] ADDR_DIGIT  = PERIPH_BASE + 32'h14;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  localparam int MEMREAD_BIT  = 4;
  localparam int MEMWRITE_BIT = 5;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_TH, SEL_TL, SEL_TCON, SEL_LED, SEL_SWITCH, SEL_DIGIT
  } sel_e;

  // Word-aligned decode; byte offset bits are ignored.
  function automatic sel_e addr_decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
    logic [31:0] wa;
    sel_e        sel;
    wa = {addr[31:2], 2'b00};
    if (wa < ram_bytes) begin
      sel = SEL_RAM;
    end else begin
      case (wa)
        ADDR_TH:     sel = SEL_TH;
        ADDR_TL:     sel = SEL_TL;
        ADDR_TCON:   sel = SEL_TCON;
        ADDR_LED:    sel = SEL_LED;
        ADDR_SWITCH: sel = SEL_SWITCH;
        ADDR_DIGIT:  sel = SEL_DIGIT;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/periph_timer.sv
// 32-bit reload timer: TL counts up while enabled, reloads from TH after 0xFFFF_FFFF
// and latches a sticky IRQ flag in TCON[2]; bus writes apply on the next edge.
module periph_timer
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // Reload reads the pre-write TH; a software TL write overrides counting.
  always_comb begin
    th_d = wr_th_i ? wdata_i : th_q;
    tl_d = tl_q;
    if (wr_tl_i) begin
      tl_d = wdata_i;
    end else if (ovf) begin
      tl_d = th_q;
    end else if (tcon_q[TCON_EN]) begin
      tl_d = tl_q + 32'd1;
    end
    tcon_d = wr_tcon_i ? wdata_i[2:0] : tcon_q;
    // Overflow set beats a same-cycle software clear so no interrupt is lost.
    if (ovf && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IRQ] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data RAM plus memory-mapped timer, LEDs, switches and 7-seg register.
// Reads are combinational from the address; writes commit on the next rising edge.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int MEMREAD_BIT = mips_pkg::MEMREAD_BIT,
  parameter int MEMWRITE_BIT = mips_pkg::MEMWRITE_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iAddress,
  input  logic [31:0] iControlSignal,
  input  logic [31:0] iWriteData,
  input  logic [7:0]  iSwitch,
  output logic [31:0] oReadData,
  output logic [7:0]  oLed,
  output logic [11:0] oDigit,
  output logic        oIrq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic          mem_rd, mem_wr;
  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    led_q, led_d;
  logic [11:0]   digit_q, digit_d;
  logic [31:0]   th, tl;
  logic [2:0]    tcon;
  logic          unused_ctrl;

  assign mem_rd      = iControlSignal[MEMREAD_BIT];
  assign mem_wr      = iControlSignal[MEMWRITE_BIT];
  assign unused_ctrl = ^iControlSignal;
  assign sel         = addr_decode(iAddress, RAM_BYTES);
  assign ram_idx     = iAddress[AW+1:2];

  periph_timer u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_th_i   (mem_wr && (sel == SEL_TH)),
    .wr_tl_i   (mem_wr && (sel == SEL_TL)),
    .wr_tcon_i (mem_wr && (sel == SEL_TCON)),
    .wdata_i   (iWriteData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (oIrq)
  );

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr && (sel == SEL_RAM)) begin
      ram_q[ram_idx] <= iWriteData;
    end
  end

  always_comb begin
    led_d   = (mem_wr && (sel == SEL_LED))   ? iWriteData[7:0]  : led_q;
    digit_d = (mem_wr && (sel == SEL_DIGIT)) ? iWriteData[11:0] : digit_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      digit_q <= '0;
    end else begin
      led_q   <= led_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    oReadData = '0;
    if (mem_rd) begin
      case (sel)
        SEL_RAM:    oReadData = ram_q[ram_idx];
        SEL_TH:     oReadData = th;
        SEL_TL:     oReadData = tl;
        SEL_TCON:   oReadData = {29'd0, tcon};
        SEL_LED:    oReadData = {24'd0, led_q};
        SEL_SWITCH: oReadData = {24'd0, iSwitch};
        SEL_DIGIT:  oReadData = {20'd0, digit_q};
        default:    oReadData = '0;
      endcase
    end
  end

  assign oLed   = led_q;
  assign oDigit = digit_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic against a
// memory-map reference model that tracks registers, RAM and timer per edge.
module tb_mem_access_stage;

  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIG = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iAddress, iControlSignal, iWriteData;
  logic [7:0]  iSwitch;
  logic [31:0] oReadData;
  logic [7:0]  oLed;
  logic [11:0] oDigit;
  logic        oIrq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_th, m_tl, m_led, m_digit;
  logic [2:0]  m_tcon;
  logic [31:0] mram [0:255];
  bit          mvld [0:255];

  mem_access_stage dut (
    .clk(clk), .reset(reset), .iAddress(iAddress), .iControlSignal(iControlSignal),
    .iWriteData(iWriteData), .iSwitch(iSwitch), .oReadData(oReadData),
    .oLed(oLed), .oDigit(oDigit), .oIrq(oIrq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic rd);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    if (!rd) return 32'd0;
    if (wa < 32'd1024) return mram[wa[9:2]];
    if (wa == A_TH)   return m_th;
    if (wa == A_TL)   return m_tl;
    if (wa == A_TCON) return {29'd0, m_tcon};
    if (wa == A_LED)  return m_led;
    if (wa == A_SW)   return {24'd0, iSwitch};
    if (wa == A_DIG)  return m_digit;
    return 32'd0;
  endfunction

  // Advance the model by one edge using the currently applied inputs.
  task automatic mdl_step();
    logic [31:0] wa, nxt_tl, nxt_th;
    logic [2:0]  nxt_tcon;
    logic        wr, wrapping;
    wa = iAddress & 32'hFFFF_FFFC;
    wr = iControlSignal[5];
    if (wr && wa < 32'd1024) begin
      mram[wa[9:2]] = iWriteData;
      mvld[wa[9:2]] = 1'b1;
    end
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digit = 0;
      return;
    end
    wrapping = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    nxt_tl   = m_tl;
    if (m_tcon[0]) nxt_tl = wrapping ? m_th : m_tl + 32'd1;
    nxt_th   = m_th;
    nxt_tcon = m_tcon;
    if (wr) begin
      if (wa == A_TL)   nxt_tl = iWriteData;
      if (wa == A_TH)   nxt_th = iWriteData;
      if (wa == A_TCON) nxt_tcon = iWriteData[2:0];
      if (wa == A_LED)  m_led = {24'd0, iWriteData[7:0]};
      if (wa == A_DIG)  m_digit = {20'd0, iWriteData[11:0]};
    end
    if (wrapping && m_tcon[1]) nxt_tcon[2] = 1'b1;
    m_tl = nxt_tl; m_th = nxt_th; m_tcon = nxt_tcon;
  endtask

  task automatic drive(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    iAddress = a;
    iControlSignal = $urandom;
    iControlSignal[4] = rd;
    iControlSignal[5] = wr;
    iWriteData = wd;
    #1;
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] regs [3];
    regs[0] = A_TH; regs[1] = A_TL; regs[2] = A_TCON;
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    reset = 1'b0;
    n_checks++;
    if ({oIrq, oLed, oDigit} !== 21'd0) $display("FAIL reset_outputs: irq/led/digit=%h required 0", {oIrq, oLed, oDigit});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(regs[i], 1'b1, 1'b0, 32'd0);
      n_checks++;
      if (oReadData !== 32'd0) $display("FAIL reset_timer_reg %h: read %h required 0", regs[i], oReadData);
      else n_pass++;
    end
  endtask

  task automatic test_ram();
    drive(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    drive(32'h10, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'hDEAD_BEEF) $display("FAIL ram_read: got %h required deadbeef", oReadData);
    else n_pass++;
    drive(32'h13, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'hDEAD_BEEF) $display("FAIL ram_read_unaligned: got %h required deadbeef", oReadData);
    else n_pass++;
    drive(32'h10, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'd0) $display("FAIL ram_no_memread: got %h required 0", oReadData);
    else n_pass++;
    drive(32'h10, 1'b1, 1'b1, 32'h1234_5678);
    n_checks++;
    if (oReadData !== 32'hDEAD_BEEF) $display("FAIL ram_rw_prewrite: got %h required deadbeef", oReadData);
    else n_pass++;
    tick();
    drive(32'h10, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'h1234_5678) $display("FAIL ram_rw_written: got %h required 12345678", oReadData);
    else n_pass++;
    drive(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
  endtask

  task automatic test_timer_reload();
    logic [31:0] exp_tl [4];
    logic        exp_irq [4];
    exp_tl[0] = 32'hFFFF_FFFE; exp_tl[1] = 32'hFFFF_FFFF; exp_tl[2] = 32'hFFFF_FFFC; exp_tl[3] = 32'hFFFF_FFFD;
    exp_irq[0] = 0; exp_irq[1] = 0; exp_irq[2] = 1; exp_irq[3] = 1;
    drive(A_TH, 1'b0, 1'b1, 32'hFFFF_FFFC); tick();
    drive(A_TL, 1'b0, 1'b1, 32'hFFFF_FFFE); tick();
    drive(A_TCON, 1'b0, 1'b1, 32'd3);       tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      drive(A_TL, 1'b1, 1'b0, 32'd0);
      n_checks++;
      if (oReadData !== exp_tl[i] || oIrq !== exp_irq[i])
        $display("FAIL timer_reload step %0d: tl=%h irq=%b required tl=%h irq=%b", i, oReadData, oIrq, exp_tl[i], exp_irq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_irq_race();
    // TL is 0xFFFF_FFFD: clear on a non-overflow edge, then again on the overflow edge.
    drive(A_TL, 1'b0, 1'b1, 32'hFFFF_FFFE); tick();
    drive(A_TCON, 1'b0, 1'b1, 32'd3);       tick();
    n_checks++;
    if (oIrq !== 1'b0) $display("FAIL irq_clear_normal: irq=%b required 0", oIrq);
    else n_pass++;
    drive(A_TCON, 1'b0, 1'b1, 32'd3);       tick();
    drive(A_TCON, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'd7 || oIrq !== 1'b1) $display("FAIL irq_clear_race: tcon=%h irq=%b required 7/1", oReadData, oIrq);
    else n_pass++;
    drive(A_TCON, 1'b0, 1'b1, 32'd3);       tick();
    drive(A_TCON, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'd3 || oIrq !== 1'b0) $display("FAIL irq_clear_after: tcon=%h irq=%b required 3/0", oReadData, oIrq);
    else n_pass++;
  endtask

  task automatic test_tl_collision();
    drive(A_TCON, 1'b0, 1'b1, 32'd1); tick();
    for (int i = 0; i < 2; i++) begin
      drive(A_TL, 1'b0, 1'b1, 32'h10); tick();
      drive(A_TL, 1'b1, 1'b0, 32'd0);
      n_checks++;
      if (oReadData !== 32'h10) $display("FAIL tl_write_wins %0d: tl=%h required 10", i, oReadData);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (oReadData !== 32'h11) $display("FAIL tl_free_run: tl=%h required 11", oReadData);
    else n_pass++;
    drive(A_TCON, 1'b0, 1'b1, 32'd0); tick();
    drive(A_TL, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (oReadData !== 32'h12) $display("FAIL tl_hold cycle %0d: tl=%h required 12", i, oReadData);
      else n_pass++;
    end
  endtask

  task automatic test_periph();
    iSwitch = 8'hA5;
    drive(A_SW, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'h0000_00A5) $display("FAIL switch_read: got %h required a5", oReadData);
    else n_pass++;
    drive(A_LED, 1'b0, 1'b1, 32'h1FF); tick();
    n_checks++;
    if (oLed !== 8'hFF) $display("FAIL led_write: led=%h required ff", oLed);
    else n_pass++;
    drive(A_DIG, 1'b0, 1'b1, 32'hFFFF_F123); tick();
    drive(A_DIG, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oDigit !== 12'h123 || oReadData !== 32'h123) $display("FAIL digit_write: digit=%h read=%h required 123", oDigit, oReadData);
    else n_pass++;
    drive(32'h4000_0020, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'd0) $display("FAIL unmapped_read: got %h required 0", oReadData);
    else n_pass++;
    drive(A_SW, 1'b0, 1'b1, 32'h5A); tick();
    drive(A_SW, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'hA5) $display("FAIL switch_write_ignored: got %h required a5", oReadData);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp;
    logic        rd, wr;
    int          w;
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) iSwitch = 8'($urandom);
      case ($urandom_range(0, 8))
        0, 1: begin
          w = $urandom_range(0, 15);
          if (w == 4) w = 255;
          a = 32'(w * 4) + 32'($urandom_range(0, 3));
          if (!mvld[w]) rd = 1'b0;
        end
        2: a = A_TH;
        3: begin a = A_TL; if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)); end
        4: begin a = A_TCON; if ($urandom_range(0, 3) != 0) wd[0] = 1'b1; end
        5: a = A_LED;
        6: a = A_SW;
        7: a = A_DIG;
        default: a = ($urandom_range(0, 1) == 1) ? 32'h0000_0400 : 32'h4000_0018 + 32'($urandom_range(0, 7));
      endcase
      drive(a, rd, wr, wd);
      exp = mdl_read(a, rd);
      n_checks++;
      if (oReadData !== exp) $display("FAIL rand_read %0d addr %h: got %h required %h", i, a, oReadData, exp);
      else n_pass++;
      tick();
      n_checks++;
      if (oIrq !== m_tcon[2] || oLed !== m_led[7:0] || oDigit !== m_digit[11:0])
        $display("FAIL rand_state %0d: irq/led/digit=%b/%h/%h required %b/%h/%h", i, oIrq, oLed, oDigit, m_tcon[2], m_led[7:0], m_digit[11:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] regs [3];
    regs[0] = A_TH; regs[1] = A_TL; regs[2] = A_TCON;
    drive(A_TCON, 1'b0, 1'b1, 32'd0);           tick();
    drive(A_TH, 1'b0, 1'b1, 32'h0000_1234);     tick();
    drive(A_TL, 1'b0, 1'b1, 32'hFFFF_FFFE);     tick();
    drive(A_LED, 1'b0, 1'b1, 32'h3C);           tick();
    drive(A_DIG, 1'b0, 1'b1, 32'hABC);          tick();
    drive(A_TCON, 1'b0, 1'b1, 32'd3);           tick();
    drive(32'd0, 1'b0, 1'b0, 32'd0);
    tick(); tick();
    n_checks++;
    if (oIrq !== 1'b1) $display("FAIL pre_reset_irq: irq=%b required 1", oIrq);
    else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({oIrq, oLed, oDigit} !== 21'd0) $display("FAIL midcount_reset_outputs: irq/led/digit=%h required 0", {oIrq, oLed, oDigit});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(regs[i], 1'b1, 1'b0, 32'd0);
      n_checks++;
      if (oReadData !== 32'd0) $display("FAIL midcount_reset_reg %h: read %h required 0", regs[i], oReadData);
      else n_pass++;
    end
    drive(32'h10, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (oReadData !== 32'hDEAD_BEEF) $display("FAIL ram_survives_reset: got %h required deadbeef", oReadData);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mram[i] = 32'd0; mvld[i] = 1'b0; end
    reset = 1'b0; iSwitch = 8'h00;
    iAddress = 32'd0; iControlSignal = 32'd0; iWriteData = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_ram();
    test_timer_reload();
    test_irq_race();
    test_tl_collision();
    test_periph();
    test_random();
    test_reset_midcount();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
